fb_readback_tx: RTL and testbench
=================================

Name: fb_readback_tx

Overview:
- Transmit side of the framebuffer image-load path: on request, reads one 64-pixel line (128 bytes) from the framebuffer's 8-bit port and serialises it over a UART TX pin.
- The frame is a header, the row id, the data and an XOR checksum.
- Lets the host verify what the control path wrote into RAM.
- Sits beside the control module on clk_root and shares the 8-bit framebuffer port through an external mux; this block owns the port only while busy=1.

Parameters:
- UART_TICKS_PER_BIT, 9'd434, clk_in cycles per UART bit (115200 baud at 50 MHz).
- UART_TICKS_PER_BIT_WIDTH, 4'd9, width of the bit-tick counter.
- BYTES_PER_ROW, 8'd128, data bytes per line (64 px × RGB565).
- ROW_ADDR_WIDTH, 3'd5, row index width (32 rows).
- HEADER_BYTE, 8'h52, first byte of every frame ("R").

Ports:
- clk_in  input  1  system clock (clk_root).
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request pulse.
- row_in  input  5  row to dump; sampled only when start is accepted.
- busy  output  1  high from the cycle after acceptance until done.
- done  output  1  one-cycle pulse after the checksum stop bit ends.
- ram_address  output  12  {row, byte_index[6:0]}.
- ram_clk_enable  output  1  read strobe, one cycle per byte.
- ram_data_in  input  8  RAM read data, valid the cycle after the strobe.
- tx_out  output  1  UART line, 8N1, idle high.
- checksum  output  8  running XOR of the data bytes sent so far.

Behaviour:
- Reset (reset=0, async): state=IDLE; tx_out=1; busy=0; done=0; ram_clk_enable=0; ram_address=0; checksum=0. Asserting reset mid-frame aborts immediately with tx_out high; no partial-byte recovery.
- start accepted only in IDLE. In the same edge: latch row_in, clear checksum and byte_index, go to SEND_HDR. start while busy is ignored with no queuing.
- States:
  - IDLE.
  - SEND_HDR: transmit HEADER_BYTE.
  - SEND_ROW: transmit {3'b0,row}.
  - RD_ISSUE: ram_address={row,byte_index}, ram_clk_enable=1 for exactly 1 cycle.
  - RD_CAPTURE: register ram_data_in and XOR it into checksum.
  - SEND_DATA: transmit the captured byte. On tx byte-complete: if byte_index==BYTES_PER_ROW-1, go to SEND_SUM; else byte_index+1, go to RD_ISSUE.
  - SEND_SUM: transmit checksum.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- ram_clk_enable is 0 in every state except RD_ISSUE. ram_address holds its last value otherwise.
- UART framing: start bit 0, 8 data bits LSB first, stop bit 1. Each bit lasts exactly UART_TICKS_PER_BIT cycles. The tx load cycle drives the start bit on the next edge.
- Inter-byte gap (idle-high cycles between one stop bit's end and the next start bit's start):
  - header→row: 1 cycle.
  - row or data→next data: 3 cycles (RD_ISSUE, RD_CAPTURE, load).
  - last data→checksum: 1 cycle.
- Totals per frame: 131 bytes; busy high for 131×10×UART_TICKS_PER_BIT + ~3×129 cycles.
- byte_index is 7 bits and never wraps within a frame; it resets to 0 on acceptance.
- checksum covers the 128 data bytes only, not the header or row. It is held after DONE until the next acceptance.
- start arriving in the DONE cycle is ignored; the earliest acceptance is the first IDLE cycle.

Decomposition:
- Shared package fb_pkg: state encoding constants, FB_ROW_BYTES=128, FB_ADDR_WIDTH=12, HEADER_BYTE.
- One sub-module, uart_tx_byte: ports clk_in, reset, load, data[7:0], tx_out, busy, byte_done (1-cycle pulse at the end of the stop bit); parameterised by UART_TICKS_PER_BIT/_WIDTH.
- The top FSM sequences uart_tx_byte and the RAM strobes.

Test Plan:
- Reset and idle: hold reset=0 for 5 cycles, then release → tx_out=1, busy=0, ram_clk_enable=0 for 100 cycles; no start bit.
- Basic frame: UART_TICKS_PER_BIT=4; RAM model with a 1-cycle read returning addr[7:0]^8'hA5; start with row_in=5 → UART decoder sees 0x52, 0x05, 128 bytes ({5,i}[7:0]^0xA5 for i=0..127), then their XOR.
  - ram_address runs 0x280..0x2FF, each value strobed exactly once.
  - done pulses once, one cycle after the final stop bit.
- Timing: same run → every bit exactly 4 cycles; idle gap exactly 3 cycles between data bytes and 1 cycle after header and before checksum.
- start while busy: pulse start with row_in=9 at bytes 0, 60 and 127 → the frame stays row 5 and exactly one done pulse occurs.
- Boundary row: row_in=31, RAM all 0xFF → addresses 0xF80..0xFFF, checksum 0x00, row byte 0x1F.
- Reset mid-byte: assert reset during the data bit 3 of byte 40 → tx_out=1 asynchronously (before the next clk_in edge), busy=0. A new start with row_in=2 then produces a complete, correct frame.

Source files
------------

// File: rtl/fb_readback_tx_pkg.sv
// Shared definitions for the framebuffer readback transmitter: line geometry,
// frame header and the sequencer state encoding.
package fb_pkg;

    localparam int FB_ROW_BYTES   = 128;
    localparam int FB_ADDR_WIDTH  = 12;
    localparam int FB_ROW_WIDTH   = 5;
    localparam int FB_INDEX_WIDTH = 7;

    localparam logic [7:0] HEADER_BYTE = 8'h52;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND_HDR,
        ST_SEND_ROW,
        ST_RD_ISSUE,
        ST_RD_CAPTURE,
        ST_SEND_DATA,
        ST_SEND_SUM,
        ST_DONE
    } fb_state_t;

    // A line occupies one contiguous 128-byte window: row in the upper bits.
    function automatic logic [FB_ADDR_WIDTH-1:0] fb_line_address(
        input logic [FB_ROW_WIDTH-1:0]   row,
        input logic [FB_INDEX_WIDTH-1:0] index
    );
        return {row, index};
    endfunction

endpackage

// File: rtl/fb_readback_tx_if.sv
// Request, framebuffer read port and UART line of the readback transmitter.
// The master side is the host/RAM; the slave side is the transmitter itself.
interface fb_readback_tx_if;
    import fb_pkg::*;

    logic                     start;
    logic [FB_ROW_WIDTH-1:0]  row_in;
    logic                     busy;
    logic                     done;
    logic [FB_ADDR_WIDTH-1:0] ram_address;
    logic                     ram_clk_enable;
    logic [7:0]               ram_data_in;
    logic                     tx_out;
    logic [7:0]               checksum;

    modport master (
        output start, row_in, ram_data_in,
        input  busy, done, ram_address, ram_clk_enable, tx_out, checksum
    );

    modport slave (
        input  start, row_in, ram_data_in,
        output busy, done, ram_address, ram_clk_enable, tx_out, checksum
    );

endinterface

// File: rtl/fb_readback_tx_uart_tx_byte.sv
// 8N1 UART byte transmitter: load in idle, start bit on the next edge,
// byte_done high during the last cycle of the stop bit.
module uart_tx_byte #(
    parameter int UART_TICKS_PER_BIT       = 434,
    parameter int UART_TICKS_PER_BIT_WIDTH = 9
) (
    input  logic       clk_in,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx_out,
    output logic       busy,
    output logic       byte_done
);

    localparam logic [UART_TICKS_PER_BIT_WIDTH-1:0] TICK_LAST =
        UART_TICKS_PER_BIT_WIDTH'(UART_TICKS_PER_BIT - 1);
    localparam logic [UART_TICKS_PER_BIT_WIDTH-1:0] TICK_ONE =
        UART_TICKS_PER_BIT_WIDTH'(1);

    logic [UART_TICKS_PER_BIT_WIDTH-1:0] tick_count;
    logic [3:0]                          bit_index;
    logic [8:0]                          shift_reg;
    logic                                tx_reg;
    logic                                active;

    assign tx_out    = tx_reg;
    assign busy      = active;
    assign byte_done = active && (tick_count == TICK_LAST) && (bit_index == 4'd9);

    // bit_index 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            tx_reg     <= 1'b1;
            active     <= 1'b0;
            tick_count <= '0;
            bit_index  <= '0;
            shift_reg  <= '1;
        end else if (!active) begin
            if (load) begin
                tx_reg     <= 1'b0;
                shift_reg  <= {1'b1, data};
                active     <= 1'b1;
                tick_count <= '0;
                bit_index  <= '0;
            end
        end else if (tick_count == TICK_LAST) begin
            tick_count <= '0;
            if (bit_index == 4'd9) begin
                active <= 1'b0;
            end else begin
                tx_reg    <= shift_reg[0];
                shift_reg <= {1'b1, shift_reg[8:1]};
                bit_index <= bit_index + 4'd1;
            end
        end else begin
            tick_count <= tick_count + TICK_ONE;
        end
    end

endmodule

// File: rtl/fb_readback_tx.sv
// Framebuffer line readback: sends header, row id, 128 RAM bytes and their
// XOR over UART, reading each byte just before it is transmitted.
module fb_readback_tx
    import fb_pkg::*;
#(
    parameter int UART_TICKS_PER_BIT       = 434,
    parameter int UART_TICKS_PER_BIT_WIDTH = 9
) (
    input  logic             clk_in,
    input  logic             reset,
    fb_readback_tx_if.slave  bus
);

    localparam logic [FB_INDEX_WIDTH-1:0] LAST_INDEX = FB_INDEX_WIDTH'(FB_ROW_BYTES - 1);

    fb_state_t                 state, state_next;
    logic [FB_ROW_WIDTH-1:0]   row_q;
    logic [FB_INDEX_WIDTH-1:0] byte_index, byte_index_next;
    logic [7:0]                data_q;
    logic [7:0]                checksum_q;
    logic [FB_ADDR_WIDTH-1:0]  ram_address_q;
    logic                      tx_load, tx_busy, tx_done, tx_line;
    logic [7:0]                tx_data;

    uart_tx_byte #(
        .UART_TICKS_PER_BIT       (UART_TICKS_PER_BIT),
        .UART_TICKS_PER_BIT_WIDTH (UART_TICKS_PER_BIT_WIDTH)
    ) u_uart (
        .clk_in    (clk_in),
        .reset     (reset),
        .load      (tx_load),
        .data      (tx_data),
        .tx_out    (tx_line),
        .busy      (tx_busy),
        .byte_done (tx_done)
    );

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_next;
    end

    // Each SEND state loads the UART in its first cycle (UART still idle) and
    // leaves on byte_done, which keeps the inter-byte gaps at 1 or 3 cycles.
    always_comb begin
        state_next      = state;
        byte_index_next = byte_index;
        tx_load         = 1'b0;
        tx_data         = 8'h00;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next      = ST_SEND_HDR;
                    byte_index_next = '0;
                end
            end
            ST_SEND_HDR: begin
                tx_data = HEADER_BYTE;
                tx_load = !tx_busy;
                if (tx_done) state_next = ST_SEND_ROW;
            end
            ST_SEND_ROW: begin
                tx_data = {3'b000, row_q};
                tx_load = !tx_busy;
                if (tx_done) state_next = ST_RD_ISSUE;
            end
            ST_RD_ISSUE:   state_next = ST_RD_CAPTURE;
            ST_RD_CAPTURE: state_next = ST_SEND_DATA;
            ST_SEND_DATA: begin
                tx_data = data_q;
                tx_load = !tx_busy;
                if (tx_done) begin
                    if (byte_index == LAST_INDEX) begin
                        state_next = ST_SEND_SUM;
                    end else begin
                        byte_index_next = byte_index + 7'd1;
                        state_next      = ST_RD_ISSUE;
                    end
                end
            end
            ST_SEND_SUM: begin
                tx_data = checksum_q;
                tx_load = !tx_busy;
                if (tx_done) state_next = ST_DONE;
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // The read address is registered on entry to RD_ISSUE and then held.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            row_q         <= '0;
            byte_index    <= '0;
            data_q        <= '0;
            checksum_q    <= '0;
            ram_address_q <= '0;
        end else begin
            byte_index <= byte_index_next;
            if (state == ST_IDLE && bus.start) begin
                row_q      <= bus.row_in;
                checksum_q <= '0;
            end
            if (state_next == ST_RD_ISSUE) begin
                ram_address_q <= fb_line_address(row_q, byte_index_next);
            end
            if (state == ST_RD_CAPTURE) begin
                data_q     <= bus.ram_data_in;
                checksum_q <= checksum_q ^ bus.ram_data_in;
            end
        end
    end

    assign bus.busy           = (state != ST_IDLE) && (state != ST_DONE);
    assign bus.done           = (state == ST_DONE);
    assign bus.ram_clk_enable = (state == ST_RD_ISSUE);
    assign bus.ram_address    = ram_address_q;
    assign bus.checksum       = checksum_q;
    assign bus.tx_out         = tx_line;

endmodule

// File: tb/tb_fb_readback_tx.sv
// Directed bench for fb_readback_tx: decodes the UART line at 4 clocks/bit and
// compares frames, strobes, gaps and done timing against hand-derived values.
module tb_fb_readback_tx;

    localparam int TICKS  = 4;
    localparam int BUDGET = 8000;

    logic clk_in = 1'b0;
    logic reset;

    always #5 clk_in = ~clk_in;

    fb_readback_tx_if bus();

    fb_readback_tx #(
        .UART_TICKS_PER_BIT       (TICKS),
        .UART_TICKS_PER_BIT_WIDTH (9)
    ) dut (
        .clk_in (clk_in),
        .reset  (reset),
        .bus    (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Modes: 0 addr^A5, 1 all FF, 2 addr*7+3, 3 all zero.
    int         ram_mode;
    logic [7:0] ram_q;

    function automatic logic [7:0] ramValue(input logic [11:0] addr, input int mode);
        case (mode)
            0:       return addr[7:0] ^ 8'hA5;
            1:       return 8'hFF;
            2:       return 8'(addr[7:0] * 8'd7 + 8'd3);
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        ram_q = 8'h00;
        forever begin
            @(posedge clk_in);
            if (bus.ram_clk_enable) ram_q <= ramValue(bus.ram_address, ram_mode);
        end
    end
    assign bus.ram_data_in = ram_q;

    int          cyc, rx_count, idle_cnt, cur_gap, cur_sample;
    int          bit_err, frame_err, done_cnt, done_cyc, last_end_cyc;
    bit          in_byte;
    logic [39:0] smp;
    logic [7:0]  rxb;
    logic [7:0]  rx_bytes[$];
    int          rx_gaps[$];
    logic [11:0] strobes[$];

    // Line decoder, strobe recorder and done counter, all sampled on negedge.
    initial begin
        cyc = 0; rx_count = 0; idle_cnt = 0; cur_gap = 0; cur_sample = 0;
        bit_err = 0; frame_err = 0; done_cnt = 0; done_cyc = 0; last_end_cyc = 0;
        in_byte = 1'b0; smp = '1;
        forever begin
            @(negedge clk_in);
            cyc++;
            if (reset !== 1'b1) begin
                in_byte = 1'b0; cur_sample = 0; idle_cnt = 0;
            end else begin
                if (bus.ram_clk_enable) strobes.push_back(bus.ram_address);
                if (bus.done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                if (!in_byte) begin
                    if (bus.tx_out == 1'b0) begin
                        in_byte = 1'b1; smp = '1; smp[0] = 1'b0; cur_sample = 1;
                        cur_gap = idle_cnt;
                    end else begin
                        idle_cnt++;
                    end
                end else begin
                    smp[cur_sample] = bus.tx_out;
                    cur_sample++;
                    if (cur_sample == 40) begin
                        for (int b = 0; b < 10; b++)
                            for (int j = 1; j < 4; j++)
                                if (smp[4*b+j] !== smp[4*b]) bit_err++;
                        if (smp[0] !== 1'b0 || smp[36] !== 1'b1) frame_err++;
                        for (int k = 0; k < 8; k++) rxb[k] = smp[4*(k+1)];
                        rx_bytes.push_back(rxb);
                        rx_gaps.push_back(cur_gap);
                        rx_count++;
                        last_end_cyc = cyc;
                        in_byte = 1'b0; cur_sample = 0; idle_cnt = 0;
                    end
                end
            end
        end
    end

    task automatic clearCapture();
        rx_bytes.delete(); rx_gaps.delete(); strobes.delete();
        rx_count = 0; done_cnt = 0; bit_err = 0; frame_err = 0;
    endtask

    task automatic applyStimulus(input logic [4:0] row);
        @(negedge clk_in);
        bus.start  = 1'b1;
        bus.row_in = row;
        @(negedge clk_in);
        bus.start  = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk_in);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        if (!seen) checkOutput(tag, 0, 1);
    endtask

    task automatic waitRx(input int target, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < BUDGET && !seen; i++) begin
            @(negedge clk_in);
            if (rx_count >= target) seen = 1'b1;
        end
        if (!seen) checkOutput(tag, 0, 1);
    endtask

    task automatic injectBusyStarts();
        int targets[3] = '{2, 62, 129};
        for (int t = 0; t < 3; t++) begin
            waitRx(targets[t], "inject_timeout");
            bus.start  = 1'b1;
            bus.row_in = 5'd9;
            @(negedge clk_in);
            bus.start  = 1'b0;
        end
    endtask

    function automatic string tg(input int id, input string name);
        return $sformatf("f%0d_%s", id, name);
    endfunction

    task automatic checkFrame(input int id, input logic [4:0] row, input int mode);
        logic [7:0] exp_sum = 8'h00;
        int bad_data = 0, bad_gap = 0, bad_addr = 0;
        for (int i = 0; i < 128; i++) exp_sum ^= ramValue({row, 7'(i)}, mode);
        checkOutput(tg(id, "byte_count"), rx_bytes.size(), 131);
        checkOutput(tg(id, "strobe_count"), strobes.size(), 128);
        if (rx_bytes.size() == 131) begin
            checkOutput(tg(id, "header"), rx_bytes[0], 8'h52);
            checkOutput(tg(id, "row_byte"), rx_bytes[1], {3'b000, row});
            for (int i = 0; i < 128; i++)
                if (rx_bytes[i+2] !== ramValue({row, 7'(i)}, mode)) bad_data++;
            checkOutput(tg(id, "data_errors"), bad_data, 0);
            checkOutput(tg(id, "sum_byte"), rx_bytes[130], exp_sum);
            for (int k = 2; k < 130; k++) if (rx_gaps[k] != 3) bad_gap++;
            checkOutput(tg(id, "gap_hdr_row"), rx_gaps[1], 1);
            checkOutput(tg(id, "gap_data_errors"), bad_gap, 0);
            checkOutput(tg(id, "gap_last_sum"), rx_gaps[130], 1);
        end
        if (strobes.size() == 128) begin
            for (int i = 0; i < 128; i++)
                if (strobes[i] !== {row, 7'(i)}) bad_addr++;
            checkOutput(tg(id, "first_addr"), strobes[0], {row, 7'd0});
            checkOutput(tg(id, "addr_errors"), bad_addr, 0);
        end
        checkOutput(tg(id, "checksum_port"), bus.checksum, exp_sum);
        checkOutput(tg(id, "done_pulses"), done_cnt, 1);
        checkOutput(tg(id, "done_delay"), done_cyc - last_end_cyc, 1);
        checkOutput(tg(id, "bit_timing"), bit_err, 0);
        checkOutput(tg(id, "framing"), frame_err, 0);
        checkOutput(tg(id, "busy_after"), bus.busy, 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int bad;
        reset      = 1'b0;
        bus.start  = 1'b0;
        bus.row_in = 5'd0;
        ram_mode   = 0;

        repeat (5) @(negedge clk_in);
        checkOutput("rst_tx_out", bus.tx_out, 1);
        checkOutput("rst_busy", bus.busy, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_ram_ce", bus.ram_clk_enable, 0);
        checkOutput("rst_ram_addr", bus.ram_address, 0);
        checkOutput("rst_checksum", bus.checksum, 0);
        reset = 1'b1;

        bad = 0;
        repeat (100) begin
            @(negedge clk_in);
            if (bus.tx_out !== 1'b1 || bus.busy !== 1'b0 || bus.ram_clk_enable !== 1'b0) bad++;
        end
        checkOutput("idle_quiet", bad, 0);
        checkOutput("idle_no_bytes", rx_count, 0);

        // Row 5 with start pulses (row 9) injected while busy.
        clearCapture();
        ram_mode = 0;
        fork
            begin
                applyStimulus(5'd5);
                waitDone("f1_done_timeout");
            end
            injectBusyStarts();
        join
        repeat (3) @(negedge clk_in);
        checkFrame(1, 5'd5, 0);
        bad = 0;
        repeat (100) begin
            @(negedge clk_in);
            if (bus.busy !== 1'b0) bad++;
        end
        checkOutput("f1_no_requeue_busy", bad, 0);
        checkOutput("f1_no_requeue_bytes", rx_count, 131);

        // Boundary row with all-FF RAM; start raised in the DONE cycle.
        clearCapture();
        ram_mode = 1;
        applyStimulus(5'd31);
        waitDone("f2_done_timeout");
        bus.start  = 1'b1;
        bus.row_in = 5'd3;
        @(negedge clk_in);
        bus.start  = 1'b0;
        bad = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (bus.busy !== 1'b0) bad++;
        end
        checkOutput("f2_start_in_done_ignored", bad, 0);
        checkFrame(2, 5'd31, 1);

        // Abort during data bit 3 of data byte 40 (all-zero RAM, so the line is low).
        clearCapture();
        ram_mode = 3;
        applyStimulus(5'd7);
        begin
            bit seen = 1'b0;
            for (int i = 0; i < BUDGET && !seen; i++) begin
                @(negedge clk_in);
                #1;
                if (rx_count == 42 && in_byte && cur_sample == 18) seen = 1'b1;
            end
            checkOutput("abort_point_reached", seen, 1);
        end
        checkOutput("pre_abort_bit", bus.tx_out, 0);
        #1 reset = 1'b0;
        #1;
        checkOutput("abort_tx_async", bus.tx_out, 1);
        checkOutput("abort_busy", bus.busy, 0);
        repeat (3) @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);

        clearCapture();
        ram_mode = 2;
        applyStimulus(5'd2);
        waitDone("f3_done_timeout");
        repeat (3) @(negedge clk_in);
        checkFrame(3, 5'd2, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
